// File: rtl/irq_controller.sv
// irq_controller: collects 16 peripheral event lines into pending flags,
// arbitrates them by per-pair programmable priority and drives the CPU
// interrupt level. During the acknowledge phase it returns the vector number.
//
// Optional feature macro: IRQ_CTRL_AUTO_CLEAR_EN
//   defined   - entering ACK with a real winner clears that source's flag
//   undefined - flags clear only through software write-1-to-clear
//
// Ports:
//   clk, reset (async, active-low)
//   bus_write, bus_read, bus_address_in[23:0], bus_data_in[7:0] : register bus
//   bus_data_out[7:0]  : read data or vector, 8'h00 when not addressed
//   src[15:0]          : raw event lines, rising edge sets the flag
//   iack               : CPU interrupt acknowledge
//   read_interrupt_vector : CPU vector-fetch phase
//   irq[3:0]           : one-hot level 3..1 in bits 3..1, bit 0 always 0
//
// Register map (BASE_ADDR + offset):
//   0 PRI_LO, 1 PRI_HI, 3 EN_LO, 4 EN_HI, 7 FLAG_LO, 8 FLAG_HI (W1C)
//   2, 5, 6 read as 0 and ignore writes

module irq_controller #(
    parameter logic [23:0] BASE_ADDR  = 24'h2020,
    parameter logic [7:0]  VEC_OFFSET = 8'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [15:0] src,
    input  logic        iack,
    input  logic        read_interrupt_vector,
    output logic [3:0]  irq
);

    localparam int unsigned NUM_SRC  = 16;
    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LVL_W    = 2;
    localparam int unsigned WIN_SIZE = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   pri_q;
    logic [NUM_SRC-1:0]   en_q;
    logic [NUM_SRC-1:0]   flag_q;
    logic [NUM_SRC-1:0]   src_q;
    logic [NUM_SRC-1:0]   rise_q;
    logic [NUM_SRC-1:0]   flag_clr;
    logic [IDX_W-1:0]     ack_idx_q;
    logic [LVL_W-1:0]     ack_lvl_q;
    logic                 ack_spur_q;

    logic [ADDR_W-1:0]    offset;
    logic                 hit;
    logic [3:0]           reg_sel;
    logic                 wr;
    logic [DATA_W-1:0]    reg_rd;

    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    logic [LVL_W-1:0]     win_lvl;
    logic                 ack_entry;

    // Level to one-hot irq encoding; level 0 means no request.
    function automatic logic [3:0] lvl_onehot(input logic [LVL_W-1:0] lvl);
        logic [3:0] oh;
        case (lvl)
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Address decode of the 9-byte window.
    assign offset  = bus_address_in - BASE_ADDR;
    assign hit     = (offset < ADDR_W'(WIN_SIZE));
    assign reg_sel = offset[3:0];
    assign wr      = bus_write && hit;

    // Highest priority wins; strict '>' keeps the lowest index on ties.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_lvl   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (flag_q[i] && en_q[i] && (pri_q[2*(i/2) +: 2] > win_lvl)) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                win_lvl   = pri_q[2*(i/2) +: 2];
            end
        end
    end

    assign ack_entry = (state_q == ST_IDLE) && iack;

    // Flag clear requests: software W1C plus optional clear on acknowledge.
    always_comb begin
        flag_clr = '0;
        if (wr && (reg_sel == 4'h7)) flag_clr[7:0]  = bus_data_in;
        if (wr && (reg_sel == 4'h8)) flag_clr[15:8] = bus_data_in;
`ifdef IRQ_CTRL_AUTO_CLEAR_EN
        if (ack_entry && win_valid) flag_clr[win_idx] = 1'b1;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (iack)  state_d = ST_ACK;
            ST_ACK:  if (!iack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registers, edge detection, acknowledge latch and registered irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pri_q      <= '0;
            en_q       <= '0;
            flag_q     <= '0;
            src_q      <= '0;
            rise_q     <= '0;
            ack_idx_q  <= '0;
            ack_lvl_q  <= '0;
            ack_spur_q <= 1'b0;
            irq        <= '0;
        end else begin
            src_q  <= src;
            rise_q <= src & ~src_q;
            // A set arriving with a clear wins.
            flag_q <= (flag_q & ~flag_clr) | rise_q;
            if (wr && (reg_sel == 4'h0)) pri_q[7:0]  <= bus_data_in;
            if (wr && (reg_sel == 4'h1)) pri_q[15:8] <= bus_data_in;
            if (wr && (reg_sel == 4'h3)) en_q[7:0]   <= bus_data_in;
            if (wr && (reg_sel == 4'h4)) en_q[15:8]  <= bus_data_in;
            if (ack_entry) begin
                ack_idx_q  <= win_idx;
                ack_lvl_q  <= win_lvl;
                ack_spur_q <= !win_valid;
            end
            // In ACK the request level stays at the latched value.
            irq <= lvl_onehot((state_q == ST_IDLE) ? win_lvl : ack_lvl_q);
        end
    end

    // Register read mux.
    always_comb begin
        reg_rd = '0;
        case (reg_sel)
            4'h0:    reg_rd = pri_q[7:0];
            4'h1:    reg_rd = pri_q[15:8];
            4'h3:    reg_rd = en_q[7:0];
            4'h4:    reg_rd = en_q[15:8];
            4'h7:    reg_rd = flag_q[7:0];
            4'h8:    reg_rd = flag_q[15:8];
            default: reg_rd = '0;
        endcase
    end

    // Vector fetch takes precedence over register reads; idle bus reads 0.
    always_comb begin
        bus_data_out = '0;
        if ((state_q == ST_ACK) && read_interrupt_vector && bus_read) begin
            bus_data_out = ack_spur_q ? 8'hFF : (VEC_OFFSET + DATA_W'(ack_idx_q));
        end else if (bus_read && hit) begin
            bus_data_out = reg_rd;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of flags, priorities,
// enables and the acknowledge handshake.

module tb_irq_controller;

    localparam logic [23:0] BASE = 24'h2020;
    localparam logic [7:0]  VOFF = 8'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [23:0] bus_address_in = '0;
    logic [7:0]  bus_data_in = '0;
    logic [7:0]  bus_data_out;
    logic [15:0] src = '0;
    logic        iack = 1'b0;
    logic        read_interrupt_vector = 1'b0;
    logic [3:0]  irq;

    irq_controller #(.BASE_ADDR(BASE), .VEC_OFFSET(VOFF)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .bus_write             (bus_write),
        .bus_read              (bus_read),
        .bus_address_in        (bus_address_in),
        .bus_data_in           (bus_data_in),
        .bus_data_out          (bus_data_out),
        .src                   (src),
        .iack                  (iack),
        .read_interrupt_vector (read_interrupt_vector),
        .irq                   (irq)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    int m_lvl[8];
    bit m_en[16];
    bit m_flag[16];
    bit s1[16];      // src sampled at the previous edge
    bit s2[16];      // src sampled two edges ago
    bit m_ack;
    bit m_spur;
    int m_aidx;
    int m_irq_lvl;

    function automatic void m_reset();
        for (int g = 0; g < 8; g++) m_lvl[g] = 0;
        for (int i = 0; i < 16; i++) begin
            m_en[i] = 0; m_flag[i] = 0; s1[i] = 0; s2[i] = 0;
        end
        m_ack = 0; m_spur = 0; m_aidx = 0; m_irq_lvl = 0;
    endfunction

    // Search levels from high to low, first matching index wins.
    function automatic int m_winner();
        for (int lv = 3; lv >= 1; lv--)
            for (int i = 0; i < 16; i++)
                if (m_flag[i] && m_en[i] && m_lvl[i/2] == lv) return i;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int lv);
        logic [3:0] r;
        r = '0;
        if (lv > 0) r[lv] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] m_read(input int off);
        logic [7:0] r;
        r = '0;
        case (off)
            0: for (int g = 0; g < 4; g++) r[2*g +: 2] = 2'(m_lvl[g]);
            1: for (int g = 0; g < 4; g++) r[2*g +: 2] = 2'(m_lvl[g+4]);
            3: for (int b = 0; b < 8; b++) r[b] = m_en[b];
            4: for (int b = 0; b < 8; b++) r[b] = m_en[b+8];
            7: for (int b = 0; b < 8; b++) r[b] = m_flag[b];
            8: for (int b = 0; b < 8; b++) r[b] = m_flag[b+8];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance one clock with current inputs, update model, check irq.
    task automatic tick();
        int w;
        int wl;
        int off;
        bit nf[16];
        off = 32'(bus_address_in - BASE);
        if (!reset) begin
            @(posedge clk);
            #1;
            check("irq_in_reset", 32'(irq), 32'(0));
            return;
        end
        w  = m_winner();
        wl = (w >= 0) ? m_lvl[w/2] : 0;
        for (int i = 0; i < 16; i++) begin
            nf[i] = m_flag[i];
            if (bus_write && off == 7 && i < 8 && bus_data_in[i]) nf[i] = 0;
            if (bus_write && off == 8 && i >= 8 && bus_data_in[i-8]) nf[i] = 0;
`ifdef IRQ_CTRL_AUTO_CLEAR_EN
            if (!m_ack && iack && i == w) nf[i] = 0;
`endif
            if (s1[i] && !s2[i]) nf[i] = 1;
        end
        for (int i = 0; i < 16; i++) begin
            m_flag[i] = nf[i];
            s2[i] = s1[i];
            s1[i] = src[i];
        end
        if (bus_write) begin
            case (off)
                0: for (int g = 0; g < 4; g++) m_lvl[g]   = int'((bus_data_in >> (2*g)) & 8'h03);
                1: for (int g = 0; g < 4; g++) m_lvl[g+4] = int'((bus_data_in >> (2*g)) & 8'h03);
                3: for (int b = 0; b < 8; b++) m_en[b]   = bus_data_in[b];
                4: for (int b = 0; b < 8; b++) m_en[b+8] = bus_data_in[b];
                default: ;
            endcase
        end
        if (!m_ack) begin
            m_irq_lvl = wl;
            if (iack) begin
                m_ack = 1; m_spur = (w < 0); m_aidx = w;
            end
        end else if (!iack) begin
            m_ack = 0;
        end
        @(posedge clk);
        #1;
        check("irq", 32'(irq), 32'(onehot(m_irq_lvl)));
    endtask

    task automatic wr(input int off, input logic [7:0] data);
        bus_address_in = BASE + 24'(off);
        bus_data_in = data;
        bus_write = 1'b1;
        tick();
        bus_write = 1'b0;
    endtask

    task automatic rd(input int off, output logic [7:0] d);
        bus_address_in = BASE + 24'(off);
        bus_read = 1'b1;
        #2;
        d = bus_data_out;
        bus_read = 1'b0;
    endtask

    task automatic rd_vec(output logic [7:0] d);
        bus_address_in = 24'h000000;
        read_interrupt_vector = 1'b1;
        bus_read = 1'b1;
        #2;
        d = bus_data_out;
        read_interrupt_vector = 1'b0;
        bus_read = 1'b0;
    endtask

    task automatic check_regs();
        logic [7:0] d;
        for (int off = 0; off < 10; off++) begin
            rd(off, d);
            check($sformatf("reg_off%0d", off), 32'(d), 32'(m_read(off)));
        end
    endtask

    task automatic check_vec();
        logic [7:0] d;
        logic [7:0] e;
        rd_vec(d);
        if (!m_ack)     e = 8'h00;
        else if (m_spur) e = 8'hFF;
        else             e = VOFF + 8'(m_aidx);
        check("vector", 32'(d), 32'(e));
    endtask

    initial begin
        logic [7:0] d;
        int r;

        // Reset with all sources held high.
        m_reset();
        reset = 1'b0;
        src = 16'hFFFF;
        tick();
        tick();
        check_regs();
        rd(7, d);
        check("rst_flag_lo", 32'(d), 32'(8'h00));
        reset = 1'b1;
        tick();
        rd(7, d);
        check("flag_after_edge1", 32'(d), 32'(8'h00));
        tick();
        rd(7, d);
        check("flag_lo_after_edge2", 32'(d), 32'(8'hFF));
        rd(8, d);
        check("flag_hi_after_edge2", 32'(d), 32'(8'hFF));
        src = 16'h0000;
        wr(7, 8'hFF);
        wr(8, 8'hFF);
        tick();
        check_regs();

        // Single source at level 3, latency and W1C.
        wr(0, 8'h03);
        wr(3, 8'h01);
        src = 16'h0001;
        tick();
        src = 16'h0000;
        tick();
        check("irq_n1", 32'(irq), 32'(4'b0000));
        tick();
        check("irq_n2", 32'(irq), 32'(4'b1000));
        rd(7, d);
        check("flag_src0", 32'(d), 32'(8'h01));
        wr(7, 8'h01);
        tick();
        check("irq_after_clr", 32'(irq), 32'(4'b0000));

        // Sources 1 and 4, different then equal priorities.
        wr(0, 8'h21);
        wr(3, 8'h12);
        src = 16'h0012;
        tick();
        src = 16'h0000;
        tick();
        tick();
        check("irq_lvl2", 32'(irq), 32'(4'b0100));
        iack = 1'b1;
        tick();
        rd_vec(d);
        check("vec_src4", 32'(d), 32'(8'h07));
        iack = 1'b0;
        tick();
        tick();
        wr(0, 8'h22);
        tick();
        iack = 1'b1;
        tick();
        rd_vec(d);
        check("vec_tie_src1", 32'(d), 32'(8'h04));
        iack = 1'b0;
        tick();
        tick();

        // Spurious acknowledge; irq frozen at 0 until iack falls.
        wr(3, 8'h01);
        wr(7, 8'hFF);
        wr(8, 8'hFF);
        tick();
        iack = 1'b1;
        tick();
        rd_vec(d);
        check("vec_spurious", 32'(d), 32'(8'hFF));
        src = 16'h0001;
        tick();
        src = 16'h0000;
        tick();
        tick();
        check("irq_frozen", 32'(irq), 32'(4'b0000));
        rd_vec(d);
        check("vec_spurious_hold", 32'(d), 32'(8'hFF));
        iack = 1'b0;
        tick();
        check("irq_exit_edge", 32'(irq), 32'(4'b0000));
        tick();
        check("irq_rearb", 32'(irq), 32'(4'b0100));

        // Set and clear in the same cycle.
        wr(7, 8'hFF);
        src = 16'h0004;
        tick();
        wr(7, 8'h04);
        src = 16'h0000;
        rd(7, d);
        check("set_wins", 32'(d & 8'h04), 32'(8'h04));
        check_regs();

        // Reset in the middle of ACK.
        wr(7, 8'hFF);
        src = 16'h0001;
        tick();
        src = 16'h0000;
        tick();
        tick();
        iack = 1'b1;
        tick();
        check("irq_in_ack", 32'(irq), 32'(4'b0100));
        #20;
        reset = 1'b0;
        #1;
        m_reset();
        check("irq_async_rst", 32'(irq), 32'(4'b0000));
        check_vec();
        check_regs();
        iack = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Acknowledge of source 5 and its flag.
        wr(0, 8'h30);
        wr(3, 8'h20);
        src = 16'h0020;
        tick();
        src = 16'h0000;
        tick();
        tick();
        check("irq_src5", 32'(irq), 32'(4'b1000));
        iack = 1'b1;
        tick();
        rd_vec(d);
        check("vec_src5", 32'(d), 32'(8'h08));
        rd(7, d);
`ifdef IRQ_CTRL_AUTO_CLEAR_EN
        check("auto_clear_src5", 32'(d & 8'h20), 32'(8'h00));
`else
        check("no_auto_clear_src5", 32'(d & 8'h20), 32'(8'h20));
`endif
        iack = 1'b0;
        tick();
        tick();
        check_regs();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = int'($urandom_range(0, 99));
            src = src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            if (r < 15) begin
                bus_address_in = BASE + 24'($urandom_range(0, 9));
                bus_data_in = 8'($urandom);
                bus_write = 1'b1;
            end
            if (!iack) begin
                if ($urandom_range(0, 19) == 0) iack = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) iack = 1'b0;
            end
            tick();
            bus_write = 1'b0;
            if (m_ack) check_vec();
            if (cyc % 16 == 0) check_regs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller for the MINX top level. It collects 16 peripheral event lines, such as the PRC's `irq_copy_complete` and `irq_render_done`, timers and keys, into software-visible flag registers. It arbitrates pending sources by programmable priority and drives the s1c88 `irq[3:0]` input. During the CPU's acknowledge cycle it supplies the interrupt vector number. Its `bus_data_out` is OR-combined into `reg_data_out` with the other register blocks.

## Interface
Parameters:
- `BASE_ADDR`, default 24'h2020: base of the 9-byte register window.
- `VEC_OFFSET`, default 8'd3: vector number of source 0. Vectors 0–2 are reserved.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `bus_write` in 1: bus write strobe.
- `bus_read` in 1: bus read strobe.
- `bus_address_in` in 24: bus address.
- `bus_data_in` in 8: write data.
- `bus_data_out` out 8: read data. It is 8'h00 when the block is not addressed.
- `src` in 16: raw event lines. Bit i is source i.
- `iack` in 1: interrupt acknowledge from the CPU.
- `read_interrupt_vector` in 1: CPU vector-fetch phase.
- `irq` out 4: request level. Bits 3..1 are one-hot levels 3..1; bit 0 is always 0.

## Operation
- Registers, at `BASE_ADDR` + offset:
  - 0x0 PRI_LO and 0x1 PRI_HI: 2-bit priority per source pair (group g = sources 2g and 2g+1). PRI_LO holds groups 0–3 and PRI_HI groups 4–7, with group g at bits [2(g%4)+1 : 2(g%4)]. Priority 0 means masked.
  - 0x3 EN_LO and 0x4 EN_HI: per-source enable, read/write.
  - 0x7 FLAG_LO and 0x8 FLAG_HI: per-source pending flags. Reads return the flags. Writing 1 to a bit clears it; writing 0 has no effect.
  - Offsets 0x2, 0x5 and 0x6 read as 0 and ignore writes.
- Flag set: on a rising edge of `src[i]` (registered `src_q` compared with `src`). Flags set regardless of enable or priority.
- Set and clear in the same cycle: the set wins and the flag ends the cycle at 1.
- A source is pending when flag, enable and group priority are all nonzero.
- Winner: the pending source with the highest priority. Ties go to the lowest index.
- `irq` is one-hot at the winner's priority level, or 4'b0000 when nothing is pending.
- FSM:
  - IDLE → ACK when `iack`=1. On entry, latch the winner index and level into `ack_src`. If nothing is pending, latch a spurious marker instead.
  - ACK → IDLE when `iack`=0.
- Vector output: in ACK with `read_interrupt_vector`=1 and `bus_read`=1, `bus_data_out` = `VEC_OFFSET` + `ack_src`. A spurious acknowledge returns 8'hFF.
- In ACK, `irq` is frozen at the latched level. Arbitration resumes in IDLE.

## Timing
- Reset values: all registers 0, `src_q`=0, FSM=IDLE, `irq`=4'b0000, `bus_data_out`=8'h00.
- Register writes take effect at the `clk` posedge where `bus_write` is high and the address matches.
- Register reads are combinational from the current register state.
- Latency from a `src` edge to `irq`:
  - The flag is set at edge N+1, where N is the posedge that first samples `src[i]`=1.
  - `irq` becomes valid at edge N+2, because `irq` is registered.
- Latency from a register write to `irq`:
  - A write of priority, enable or flag-clear changes `irq` on the next edge after the write edge.
  - Setting a priority to 0 while that source is pending drops `irq` after that same one-edge latency.
- `iack` is sampled at the posedge. The vector is valid from the first cycle in ACK until `iack` falls.
- Returning from ACK to IDLE: `irq` is re-arbitrated on the first edge in IDLE.
- Reset asserted mid-ACK: the FSM returns to IDLE immediately, and all flags and `irq` clear asynchronously.
- A `src` line held high sets its flag once only. A new edge is required to set it again.

## Configuration
- `IRQ_CTRL_AUTO_CLEAR_EN` defined: entering ACK with a real winner clears that source's flag on the same edge. If a new edge of that source arrives on that edge, the set still wins.
- Undefined: flags are cleared only by software write-1-to-clear.

## Test plan
- Reset with `src`=16'hFFFF held → all registers read 0 and `irq`=0. After reset, flags read 8'hFF / 8'hFF once the second edge has sampled `src`=1.
- PRI_LO=8'h03, EN_LO=8'h01, pulse `src[0]` → FLAG_LO=8'h01 and `irq`=4'b1000 two edges after sampling. Writing FLAG_LO=8'h01 → `irq`=0 on the next edge.
- Sources 1 and 4 are both pending:
  - Group 0 at level 1 and group 2 at level 2 → `irq`=4'b0100, then `iack` → vector 8'h07.
  - Both groups at level 2 → vector 8'h04.
- `iack` with nothing pending → the vector phase returns 8'hFF, and `irq` stays 0 until `iack` falls.
- A `src[2]` edge in the same cycle as a FLAG_LO=8'h04 write → FLAG_LO reads 8'h04.
- Reset pulsed while in ACK → FSM in IDLE and `irq`=0 immediately. With `IRQ_CTRL_AUTO_CLEAR_EN`, an `iack` on source 5 (non-reset case) clears FLAG_LO bit 5 on the ACK entry edge.
